addsub_issue_ctrl: RTL and testbench
====================================

# addsub_issue_ctrl

Command sequencer upstream of the single-cycle adder-subtractor. Accepts operand/op commands on a valid/ready input, queues them, and issues them one at a time: it drives the adder's operand, operation and one-cycle start inputs, waits for its done pulse, and returns the captured sum/carry on a valid/ready output. It decouples bursty producers from the adder's start/done protocol.

## Interface
- N, 4: operand width; must match the adder's N.
- DEPTH, 4: command FIFO entries; a power of two, ≥2.
- TIMEOUT, 15: WAIT-state cycle limit; only used with the timeout feature.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept (= !full, 0 while rst).
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_op  in  1  0 add, 1 subtract.
- out_valid  out  1  result held for consumer.
- out_ready  in  1  consumer accepts result.
- out_sum  out  N  result.
- out_cout  out  1  carry out (subtract: 1 = no borrow).
- out_err  out  1  result produced by timeout, not the adder.
- as_a, as_b  out  N  to adder A/B.
- as_addsub  out  1  to adder op.
- as_start  out  1  to adder start.
- as_sum  in  N  from adder sum.
- as_cout  in  1  from adder cout.
- as_done  in  1  from adder done.
- busy  out  1  state != IDLE or FIFO non-empty.
- count  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO push on in_valid && in_ready; push and pop in the same cycle leave count unchanged. No bypass: an empty FIFO still takes one cycle before pop.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop head into as_a/as_b/as_addsub registers, go ISSUE.
- ISSUE: as_start = 1 for exactly this cycle; go WAIT.
- WAIT: as_start = 0. On as_done: capture as_sum/as_cout into out_sum/out_cout, out_err = 0, go RESP.
- RESP: out_valid = 1; out_* held stable until out_ready. On out_valid && out_ready: if FIFO non-empty, pop and go ISSUE, else go IDLE.
- as_a/as_b/as_addsub are registered and stable from ISSUE through WAIT, never changing while the adder may sample them.
- as_done is ignored outside WAIT.
- Arithmetic is the adder's: sum = A ± B mod 2^N. This block passes values through unmodified.
- At most one command is in flight.

## Timing
- Reset: state IDLE, FIFO empty, count 0, as_start 0, as_a/as_b/as_addsub 0, out_valid 0, out_sum 0, out_cout 0, out_err 0, busy 0, in_ready 0 while rst is high and 1 after.
- Latency, idle with empty FIFO: command accepted at edge t → ISSUE in cycle t+2 → as_done in cycle t+3 → out_valid in cycle t+4.
- Back-to-back issue: next as_start in the cycle after the RESP handshake. Throughput is one result per 3 cycles with out_ready held high.
- Full FIFO: in_ready = 0; in_valid is ignored.
- rst mid-operation: in-flight and queued commands are dropped and the pending result is lost. The adder shares rst.

## Configuration
- ADDSUB_ISSUE_TIMEOUT_EN defined: a WAIT-cycle counter runs. If as_done has not arrived after TIMEOUT cycles in WAIT, the block loads out_sum = 0, out_cout = 0, out_err = 1 and goes to RESP. A late done is ignored.
- Not defined: no counter; WAIT holds indefinitely; out_err is tied to 0.

## Structure
- Shared package addsub_pkg holds:
  - state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  - the default N;
  - the command-word layout {op, b, a}, width 2N+1.
- One sub-module, addsub_cmd_fifo: synchronous FIFO with parameters WIDTH and DEPTH, outputs full/empty/count, wrap-around pointers with an extra MSB.

## Test plan
- Single add, A = 4'h3, B = 4'h5, op 0, out_ready = 1 → out_valid in cycle t+4 with out_sum = 4'h8, out_cout = 0; as_start high for exactly one cycle.
- Subtract, A = 4'h3, B = 4'h5, op 1 → out_sum = 4'hE, out_cout = 0. Then A = 4'h9, B = 4'h2 → out_sum = 4'h7, out_cout = 1.
- Push 5 commands back-to-back with DEPTH = 4 and out_ready = 0 → in_ready drops once count = 4. The first result holds stable; after out_ready is released, all 5 results emerge in order.
- out_ready toggled randomly → out_sum/out_cout never change while out_valid && !out_ready; as_a/as_b never change during ISSUE/WAIT.
- rst asserted during WAIT with 3 commands queued → the next cycle shows count 0, out_valid 0, state IDLE, busy 0.
- With ADDSUB_ISSUE_TIMEOUT_EN and as_done forced low → out_valid after TIMEOUT WAIT cycles with out_err = 1, out_sum = 0. A later as_done pulse has no effect.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg
// Definitions shared by the adder-subtractor issue controller and its
// command FIFO:
//   ADDSUB_N      default operand width (must match the adder)
//   ST_*          controller state encoding
//   cmd_width()   width of one queued command word
// Command word layout, MSB to LSB: {op, b, a}
//   a  = word[N-1:0]
//   b  = word[2N-1:N]
//   op = word[2N]      (0 add, 1 subtract)
package addsub_pkg;

    localparam int ADDSUB_N = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    function automatic int cmd_width(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/addsub_issue_ctrl_if.sv
// addsub_issue_ctrl_if
// Bundles the three handshakes around the issue controller:
//   command input   in_valid/in_ready/in_a/in_b/in_op
//   result output   out_valid/out_ready/out_sum/out_cout/out_err
//   adder side      as_a/as_b/as_addsub/as_start -> adder,
//                   as_sum/as_cout/as_done       <- adder
// Modports:
//   slave  - the controller itself
//   master - the environment (command producer, result consumer, adder)
interface addsub_issue_ctrl_if #(
    parameter int N = addsub_pkg::ADDSUB_N
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_op;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_err;

    logic [N-1:0] as_a;
    logic [N-1:0] as_b;
    logic         as_addsub;
    logic         as_start;
    logic [N-1:0] as_sum;
    logic         as_cout;
    logic         as_done;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready, as_sum, as_cout, as_done,
        output in_ready, out_valid, out_sum, out_cout, out_err,
               as_a, as_b, as_addsub, as_start
    );

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready, as_sum, as_cout, as_done,
        input  in_ready, out_valid, out_sum, out_cout, out_err,
               as_a, as_b, as_addsub, as_start
    );

endinterface

// File: rtl/addsub_cmd_fifo.sv
// addsub_cmd_fifo
// Synchronous FIFO holding queued commands. The head entry is always
// visible on rd_data_o; the consumer registers it when it pops.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push_i       write wr_data_i (ignored when full)
//   wr_data_i    WIDTH-bit entry
//   pop_i        discard the head entry (ignored when empty)
//   rd_data_o    head entry
//   full_o       DEPTH entries held
//   empty_o      no entries held
//   count_o      occupancy, 0..DEPTH
module addsub_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable
    // when the index bits coincide.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rd_data_o = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/addsub_issue_ctrl.sv
// addsub_issue_ctrl
// Queues add/subtract commands and issues them one at a time to a
// start/done adder-subtractor, returning each captured result on a
// valid/ready output. Sequence per command: IDLE/RESP pop -> ISSUE
// (one-cycle as_start) -> WAIT (for as_done) -> RESP (hold until taken).
// Ports:
//   clk, rst   clock, synchronous active-high reset (shared with adder)
//   bus        addsub_issue_ctrl_if.slave: command in, result out, adder
//   busy       a command is queued or in flight
//   count      FIFO occupancy
// Build option:
//   ADDSUB_ISSUE_TIMEOUT_EN - abandon a command after TIMEOUT cycles in
//   WAIT and return sum 0, cout 0, out_err 1. Without it WAIT waits
//   forever and out_err stays 0.
module addsub_issue_ctrl
    import addsub_pkg::*;
#(
    parameter int N       = ADDSUB_N,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    addsub_issue_ctrl_if.slave     bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = cmd_width(N);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
            $error("addsub_issue_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    logic [CW-1:0] wr_cmd;
    logic [CW-1:0] rd_cmd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          timed_out;

    logic [1:0]    state_q,    state_d;
    logic [N-1:0]  as_a_q,     as_a_d;
    logic [N-1:0]  as_b_q,     as_b_d;
    logic          as_op_q,    as_op_d;
    logic [N-1:0]  out_sum_q,  out_sum_d;
    logic          out_cout_q, out_cout_d;
    logic          out_err_q,  out_err_d;

    assign wr_cmd       = {bus.in_op, bus.in_b, bus.in_a};
    assign bus.in_ready = !fifo_full && !rst;
    assign push         = bus.in_valid && bus.in_ready;

    addsub_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (wr_cmd),
        .pop_i     (pop),
        .rd_data_o (rd_cmd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (count)
    );

`ifdef ADDSUB_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    // Counts completed WAIT cycles; the last allowed cycle is TIMEOUT-1,
    // so WAIT lasts exactly TIMEOUT cycles when no done arrives.
    assign timed_out = (wait_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        as_a_d     = as_a_q;
        as_b_d     = as_b_q;
        as_op_d    = as_op_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_err_d  = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving in the final allowed cycle still wins.
                if (bus.as_done) begin
                    out_sum_d  = bus.as_sum;
                    out_cout_d = bus.as_cout;
                    out_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (timed_out) begin
                    out_sum_d  = '0;
                    out_cout_d = 1'b0;
                    out_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Operands change only on a pop, i.e. never during ISSUE or WAIT.
        if (pop) begin
            as_a_d  = rd_cmd[N-1:0];
            as_b_d  = rd_cmd[2*N-1:N];
            as_op_d = rd_cmd[2*N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            as_a_q     <= '0;
            as_b_q     <= '0;
            as_op_q    <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            as_a_q     <= as_a_d;
            as_b_q     <= as_b_d;
            as_op_q    <= as_op_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_err_q  <= out_err_d;
        end
    end

    assign bus.as_a      = as_a_q;
    assign bus.as_b      = as_b_q;
    assign bus.as_addsub = as_op_q;
    assign bus.as_start  = (state_q == ST_ISSUE);
    assign bus.out_valid = (state_q == ST_RESP);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_err   = out_err_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// tb_addsub_issue_ctrl
// Drives commands into addsub_issue_ctrl, plays the adder (start -> done
// after a chosen delay), and compares every cycle against a transaction
// model: a queue of accepted commands, the one command in flight, and its
// expected result derived from plain integer arithmetic.
// Build option: ADDSUB_ISSUE_TIMEOUT_EN adds the timeout scenario.
module tb_addsub_issue_ctrl;
    localparam int N       = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int CNTW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            busy;
    logic [CNTW-1:0] count;

    addsub_issue_ctrl_if #(.N(N)) bus ();

    addsub_issue_ctrl #(
        .N       (N),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         op;
    } cmd_s;

    cmd_s         fifo_m[$];
    cmd_s         cur;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    bit           inflight, res_ready, adder_pend, to_pend, done_legit_pend;
    bit           spurious_en = 1'b0;
    logic [N-1:0] exp_sum;
    logic         exp_cout, exp_err;
    int           adder_cnt, adder_fixed = 1, wcnt;
    int           results_seen = 0, last_hs_cyc = 0, hs_gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Expected result straight from modular arithmetic.
    function automatic void expect_for(input cmd_s c);
        int ai, bi;
        ai = int'(c.a);
        bi = int'(c.b);
        if (!c.op) begin
            exp_sum  = N'((ai + bi) % (2 ** N));
            exp_cout = (ai + bi) >= (2 ** N);
        end else begin
            exp_sum  = N'((ai - bi + (2 ** N)) % (2 ** N));
            exp_cout = (ai >= bi);
        end
        exp_err = 1'b0;
    endfunction

    // One clock: apply the inputs already driven, then check outputs at
    // the falling edge and play the adder for the next cycle.
    task automatic cycle();
        bit   push_p, hs_p, rst_p, exp_start, in_wait, legit;
        cmd_s c;
        logic [N:0] r;
        rst_p  = rst;
        push_p = !rst && bus.in_valid && (fifo_m.size() < DEPTH);
        hs_p   = !rst && res_ready && bus.out_ready;
        c.a    = bus.in_a;
        c.b    = bus.in_b;
        c.op   = bus.in_op;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.as_done = 1'b0;

        if (rst_p) begin
            fifo_m.delete();
            inflight = 0; res_ready = 0; adder_pend = 0;
            to_pend = 0; done_legit_pend = 0;
            chk("rst_count", 32'(count), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_as_start", 32'(bus.as_start), 0);
            chk("rst_as_a", 32'(bus.as_a), 0);
            chk("rst_as_b", 32'(bus.as_b), 0);
            chk("rst_as_addsub", 32'(bus.as_addsub), 0);
            chk("rst_out_sum", 32'(bus.out_sum), 0);
            chk("rst_out_cout", 32'(bus.out_cout), 0);
            chk("rst_out_err", 32'(bus.out_err), 0);
            chk("rst_in_ready", 32'(bus.in_ready), 0);
            return;
        end

        if (hs_p) begin
            inflight = 0;
            res_ready = 0;
            results_seen++;
            hs_gap = cyc - last_hs_cyc;
            last_hs_cyc = cyc;
        end
        // Only commands queued before this edge can be issued (no bypass).
        exp_start = !inflight && (fifo_m.size() > 0);
        if (push_p) fifo_m.push_back(c);
        if (done_legit_pend) res_ready = 1;
        if (to_pend) begin
            res_ready = 1;
            exp_sum = '0;
            exp_cout = 1'b0;
            exp_err = 1'b1;
        end
        done_legit_pend = 0;
        to_pend = 0;

        chk("as_start", 32'(bus.as_start), 32'(exp_start));
        if (exp_start) begin
            c = fifo_m.pop_front();
            chk("issue_a", 32'(bus.as_a), 32'(c.a));
            chk("issue_b", 32'(bus.as_b), 32'(c.b));
            chk("issue_op", 32'(bus.as_addsub), 32'(c.op));
            expect_for(c);
            cur = c;
            inflight = 1;
            adder_pend = 1;
            adder_cnt = (adder_fixed > 0) ? adder_fixed : int'($urandom_range(1, 3));
            wcnt = 0;
        end

        in_wait = inflight && !res_ready && !exp_start;
        legit = 0;
        if (adder_pend && !exp_start) begin
            chk("hold_a", 32'(bus.as_a), 32'(cur.a));
            chk("hold_b", 32'(bus.as_b), 32'(cur.b));
            chk("hold_op", 32'(bus.as_addsub), 32'(cur.op));
            adder_cnt--;
            if (adder_cnt == 0) begin
                adder_pend = 0;
                if (cur.op) r = {1'b0, cur.a} + {1'b0, ~cur.b} + 1'b1;
                else        r = {1'b0, cur.a} + {1'b0, cur.b};
                bus.as_done = 1'b1;
                bus.as_sum  = r[N-1:0];
                bus.as_cout = r[N];
                legit = in_wait;
            end
        end else if (!adder_pend && spurious_en && $urandom_range(0, 4) == 0) begin
            bus.as_done = 1'b1;
            bus.as_sum  = N'($urandom);
            bus.as_cout = 1'($urandom);
        end
        if (legit) done_legit_pend = 1;
`ifdef ADDSUB_ISSUE_TIMEOUT_EN
        if (in_wait && !legit) begin
            wcnt++;
            if (wcnt == TIMEOUT) to_pend = 1;
        end
`endif

        chk("out_valid", 32'(bus.out_valid), 32'(res_ready));
        if (res_ready) begin
            chk("out_sum", 32'(bus.out_sum), 32'(exp_sum));
            chk("out_cout", 32'(bus.out_cout), 32'(exp_cout));
            chk("out_err", 32'(bus.out_err), 32'(exp_err));
        end
        chk("count", 32'(count), 32'(fifo_m.size()));
        chk("busy", 32'(busy), 32'((fifo_m.size() > 0) || inflight));
        chk("in_ready", 32'(bus.in_ready), 32'(fifo_m.size() < DEPTH));
    endtask

    task automatic set_cmd(input logic [N-1:0] a, input logic [N-1:0] b, input logic op);
        bus.in_a  = a;
        bus.in_b  = b;
        bus.in_op = op;
    endtask

    // Single command from idle: pins latency and hand-computed results.
    task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic op,
                           input logic [N-1:0] want_sum, input logic want_cout);
        int  t0, start_e, nstart;
        bit  got;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        set_cmd(a, b, op);
        cycle();
        t0 = cyc;
        bus.in_valid = 1'b0;
        got = 0; nstart = 0; start_e = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.as_start) begin nstart++; start_e = cyc; end
            if (bus.out_valid) begin got = 1; break; end
        end
        chk("one_valid_seen", 32'(got), 1);
        chk("one_start_latency", 32'(start_e - t0), 1);
        chk("one_valid_latency", 32'(cyc - t0), 3);
        chk("one_sum_literal", 32'(bus.out_sum), 32'(want_sum));
        chk("one_cout_literal", 32'(bus.out_cout), 32'(want_cout));
        chk("one_err_literal", 32'(bus.out_err), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (bus.as_start) nstart++;
        end
        chk("one_start_pulses", 32'(nstart), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_s burst[5];
        int   acc;
        bit   will;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.as_done = 1'b0;
        bus.as_sum = '0;
        bus.as_cout = 1'b0;
        set_cmd('0, '0, 1'b0);

        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        run_one(4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
        run_one(4'h3, 4'h5, 1'b1, 4'hE, 1'b0);
        run_one(4'h9, 4'h2, 1'b1, 4'h7, 1'b1);

        // Burst of five into a four-deep queue with the consumer stalled.
        burst[0] = '{a: 4'h1, b: 4'h2, op: 1'b0};
        burst[1] = '{a: 4'hF, b: 4'h1, op: 1'b0};
        burst[2] = '{a: 4'h3, b: 4'h5, op: 1'b1};
        burst[3] = '{a: 4'h9, b: 4'h2, op: 1'b1};
        burst[4] = '{a: 4'h8, b: 4'h8, op: 1'b1};
        bus.out_ready = 1'b0;
        adder_fixed = 1;
        acc = 0;
        for (int i = 0; i < 20 && acc < 5; i++) begin
            bus.in_valid = 1'b1;
            set_cmd(burst[acc].a, burst[acc].b, burst[acc].op);
            will = bus.in_ready;
            cycle();
            if (will) acc++;
        end
        chk("burst_accepted", 32'(acc), 5);
        chk("burst_count_full", 32'(count), 4);
        chk("burst_in_ready_low", 32'(bus.in_ready), 0);
        set_cmd(4'h7, 4'h7, 1'b0);
        repeat (3) cycle();
        bus.in_valid = 1'b0;
        repeat (5) cycle();
        bus.out_ready = 1'b1;
        results_seen = 0;
        for (int i = 0; i < 60 && results_seen < 5; i++) begin
            acc = results_seen;
            cycle();
            if (results_seen != acc && results_seen >= 2)
                chk("throughput_gap", 32'(hs_gap), 3);
        end
        chk("burst_results", 32'(results_seen), 5);
        repeat (2) cycle();

        // Randomised traffic with random back-pressure and adder delay.
        spurious_en = 1'b1;
        adder_fixed = 0;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            set_cmd(N'($urandom), N'($urandom), 1'($urandom));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && (fifo_m.size() > 0 || inflight); i++) cycle();
        chk("random_drained", 32'(fifo_m.size() > 0 || inflight), 0);
        spurious_en = 1'b0;
        repeat (2) cycle();

        // Reset while one command waits and three are queued.
        adder_fixed = 12;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            set_cmd(N'(i + 1), N'(i), 1'b0);
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 3);
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        cycle();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        adder_fixed = 1;
        repeat (3) cycle();

`ifdef ADDSUB_ISSUE_TIMEOUT_EN
        begin
            int  s_e;
            bit  got;
            adder_fixed = TIMEOUT + 2;
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1;
            set_cmd(4'h6, 4'h3, 1'b0);
            cycle();
            bus.in_valid = 1'b0;
            got = 0; s_e = -1;
            for (int i = 0; i < 40; i++) begin
                cycle();
                if (bus.as_start) s_e = cyc;
                if (bus.out_valid) begin got = 1; break; end
            end
            chk("to_valid_seen", 32'(got), 1);
            chk("to_latency", 32'(cyc - s_e), TIMEOUT + 1);
            chk("to_err_literal", 32'(bus.out_err), 1);
            chk("to_sum_literal", 32'(bus.out_sum), 0);
            chk("to_cout_literal", 32'(bus.out_cout), 0);
            repeat (4) cycle();
            bus.out_ready = 1'b1;
            repeat (3) cycle();
            adder_fixed = 1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
